// File: rtl/cfg_chain_ctrl.sv
// rtl/cfg_chain_ctrl.sv - serial configuration chain sequencer with readback capture
// Shifts a parallel word LSB-first into a flip-flop chain, captures the old contents, then pulses the shadow latch.
module cfg_chain_ctrl #(
  parameter  int CHAIN_LEN = 32,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  input  logic                 hold,
  output logic                 chain_en,
  output logic                 chain_sdo,
  input  logic                 chain_sdi,
  output logic                 chain_latch,
  output logic [CHAIN_LEN-1:0] rb_data,
  output logic                 rb_valid,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

  state_t               state, state_nxt;
  logic [CHAIN_LEN-1:0] tx_shreg;
  logic [CHAIN_LEN-1:0] rx_shreg;
  logic [CNT_W-1:0]     cnt;

  always_comb begin
    state_nxt   = state;
    cfg_ready   = 1'b0;
    chain_en    = 1'b0;
    chain_latch = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        chain_en = !hold;
        if (!hold && cnt == LAST_SHIFT) state_nxt = LATCH;
      end
      LATCH: begin
        busy        = 1'b1;
        chain_latch = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_shreg is a register, so the serial bit is stable across the whole enabled cycle
  assign chain_sdo = (state == SHIFT) & tx_shreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_shreg <= '0;
      rx_shreg <= '0;
      cnt      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cfg_valid) begin
        tx_shreg <= cfg_data;
        cnt      <= '0;
      end
      if (chain_en) begin
        tx_shreg <= tx_shreg >> 1;
        rx_shreg <= {chain_sdi, rx_shreg[CHAIN_LEN-1:1]};
        cnt      <= cnt + CNT_W'(1);
      end
      // first bit captured is the old stage 0, so after CHAIN_LEN shifts rx_shreg mirrors the old chain
      if (chain_latch) begin
        rb_data  <= rx_shreg;
        rb_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// tb/tb_cfg_chain_ctrl.sv - scoreboard bench for cfg_chain_ctrl with loopback chain models
module tb_cfg_chain_ctrl;

  localparam int N  = 8;
  localparam int BN = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [N-1:0] cfg_data = '0;
  logic         hold = 1'b0;
  logic         chain_en, chain_sdo, chain_sdi, chain_latch;
  logic [N-1:0] rb_data;
  logic         rb_valid, busy;

  logic          big_rst = 1'b1;
  logic          big_valid = 1'b0;
  logic          big_ready;
  logic [BN-1:0] big_data = '0;
  logic          big_en, big_sdo, big_sdi, big_latch;
  logic [BN-1:0] big_rb;
  logic          big_rb_valid, big_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .hold(hold), .chain_en(chain_en), .chain_sdo(chain_sdo), .chain_sdi(chain_sdi),
    .chain_latch(chain_latch), .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy)
  );

  cfg_chain_ctrl #(.CHAIN_LEN(BN)) dut_big (
    .clk(clk), .rst(big_rst), .cfg_valid(big_valid), .cfg_ready(big_ready), .cfg_data(big_data),
    .hold(1'b0), .chain_en(big_en), .chain_sdo(big_sdo), .chain_sdi(big_sdi),
    .chain_latch(big_latch), .rb_data(big_rb), .rb_valid(big_rb_valid), .busy(big_busy)
  );

  // Behavioural chains: stage 0 feeds the controller, new bits enter at the top stage
  logic [N-1:0]  chain = 8'h3C;
  logic [N-1:0]  shadow = '0;
  logic [BN-1:0] big_chain = '0;
  logic [BN-1:0] big_shadow = '0;
  assign chain_sdi = chain[0];
  assign big_sdi   = big_chain[0];
  always @(posedge clk) begin
    if (chain_en) chain <= {chain_sdo, chain[N-1:1]};
    if (chain_latch) shadow <= chain;
    if (big_en) big_chain <= {big_sdo, big_chain[BN-1:1]};
    if (big_latch) big_shadow <= big_chain;
  end

  typedef struct {
    logic [N-1:0] word;
    logic [N-1:0] rb;
    bit           rb_known;
    int           t_latch;
  } exp_t;
  exp_t sb[$];

  logic [N-1:0] ref_chain = 8'h3C;
  bit           rb_known = 1'b1;

  task automatic chk(input string name, input logic [BN-1:0] act, input logic [BN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge with the transfer still in flight
  task automatic send(input logic [N-1:0] w, input bit keep, input int hold_at, input int hold_len,
                      input bit expect_latch, output int t_hs);
    int   g = 0;
    int   hl;
    exp_t it;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (!cfg_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!cfg_ready) chk("handshake_timeout", 1, 0);
    t_hs = cyc;
    hl = (hold_at >= 0) ? hold_len : 0;
    if (expect_latch) begin
      it.word = w; it.rb = ref_chain; it.rb_known = rb_known; it.t_latch = t_hs + N + 1 + hl;
      sb.push_back(it);
      ref_chain = w;
      rb_known  = 1'b1;
    end
    @(negedge clk);
    cfg_data = N'($urandom);
    if (!keep) cfg_valid = 1'b0;
    chk("ready_low_busy", cfg_ready, 0);
    chk("busy_in_shift", busy, 1);
    if (hold_at >= 0) begin
      repeat (hold_at) @(negedge clk);
      hold = 1'b1;
      for (int i = 0; i < hold_len; i++) begin
        #1;
        chk("en_low_hold", chain_en, 0);
        @(negedge clk);
      end
      hold = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!cfg_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!cfg_ready) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t         it;
    bit           pend = 1'b0;
    int           en_cnt = 0;
    logic [N-1:0] acc = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("rb_valid", rb_valid, 1);
        if (it.rb_known) chk("rb_data", rb_data, it.rb);
        chk("shadow", shadow, it.word);
        pend = 1'b0;
      end
      if (rst) en_cnt = 0;
      else begin
        if (chain_en) begin
          if (en_cnt < N) acc[en_cnt] = chain_sdo;
          en_cnt++;
        end
        if (chain_latch) begin
          if (sb.size() == 0) chk("unexpected_latch", 1, 0);
          else begin
            it = sb.pop_front();
            chk("latch_cycle", cyc, it.t_latch);
            chk("en_count", en_cnt, N);
            chk("sdo_seq", acc, it.word);
            chk("busy_in_latch", busy, 1);
            pend = 1'b1;
          end
          en_cnt = 0;
        end
      end
    end
  end

  initial begin : stim
    int            t1, t2, t3, g;
    logic [N-1:0]  w;
    logic [BN-1:0] bw, prev;
    int            en, lat;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    big_rst = 1'b0;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", chain_en, 0);
    chk("rst_latch", chain_latch, 0);
    chk("rst_sdo", chain_sdo, 0);
    chk("rst_rb_valid", rb_valid, 0);
    chk("rst_rb_data", rb_data, 0);

    send(8'hA5, 1'b0, -1, 0, 1'b1, t1);
    wait_idle();

    send(8'h01, 1'b1, -1, 0, 1'b1, t1);
    send(8'hFF, 1'b0, -1, 0, 1'b1, t2);
    chk("b2b_spacing", t2 - t1, N + 2);
    wait_idle();

    send(8'h5A, 1'b0, 3, 5, 1'b1, t1);
    wait_idle();

    for (int k = 0; k < 6; k++) begin
      w = N'($urandom);
      if ($urandom_range(0, 1) == 1) send(w, 1'b0, $urandom_range(0, N - 1), $urandom_range(1, 4), 1'b1, t1);
      else send(w, 1'b0, -1, 0, 1'b1, t1);
      wait_idle();
    end

    send(8'h00, 1'b0, -1, 0, 1'b1, t1);
    wait_idle();
    send(8'hF0, 1'b0, -1, 0, 1'b0, t1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", cfg_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rb_valid", rb_valid, 0);
    chk("abort_rb_data", rb_data, 0);
    repeat (N + 4) @(negedge clk);
    chk("abort_shadow", shadow, 8'h00);
    rb_known = 1'b0;

    cfg_data = 8'h77;
    cfg_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg_valid = 1'b0;
    chk("rst_hs_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("rst_hs_ready", cfg_ready, 1);
    chk("rst_hs_en", chain_en, 0);

    send(8'h3C, 1'b0, -1, 0, 1'b1, t1);
    wait_idle();
    send(8'hC3, 1'b0, 2, 3, 1'b1, t3);
    wait_idle();

    prev = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < BN / 32; i++) bw[i*32 +: 32] = $urandom;
      big_data = bw;
      big_valid = 1'b1;
      g = 0;
      while (!big_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      @(negedge clk);
      big_valid = 1'b0;
      en = 0;
      lat = 0;
      g = 0;
      while (g < 3000) begin
        if (big_en) en++;
        if (big_latch) lat++;
        if (big_ready) break;
        @(negedge clk);
        g++;
      end
      chk("big_en_count", en, BN);
      chk("big_latch_count", lat, 1);
      chk("big_rb_valid", big_rb_valid, 1);
      chk("big_rb_data", big_rb, prev);
      chk("big_shadow", big_shadow, bw);
      prev = bw;
    end

    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
